// File: rtl/sprite_palette_bank.sv
// Sprite palette bank: runtime-writable multi-bank colour palette with a
// pipelined index-to-RGB lookup, a transparent index and a hit-flash effect
// that blinks opaque pixels white on odd flash counts.
module sprite_palette_bank #(
   parameter  int IDX_W        = 4,
   parameter  int BANKS        = 4,
   parameter  int CH_W         = 4,
   parameter  int TRANSP_IDX   = 15,
   parameter  int FLASH_FRAMES = 8,
   localparam int BSEL_W       = $clog2(BANKS)
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                in_valid,
   input  logic [IDX_W-1:0]    in_index,
   input  logic [BSEL_W-1:0]   bank_sel,
   input  logic                wr_en,
   input  logic [BSEL_W-1:0]   wr_bank,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [3*CH_W-1:0]   wr_data,
   input  logic                frame_tick,
   input  logic                flash_start,
   output logic                out_valid,
   output logic                out_opaque,
   output logic [CH_W-1:0]     red,
   output logic [CH_W-1:0]     green,
   output logic [CH_W-1:0]     blue,
   output logic                flash_active
);

   localparam int                ENTRIES    = 2 ** IDX_W;
   localparam int                RGB_W      = 3 * CH_W;
   localparam logic [IDX_W-1:0]  TRANSP_V   = IDX_W'(TRANSP_IDX);
   localparam logic [7:0]        FLASH_LOAD = 8'(FLASH_FRAMES);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLASH = 1'b1
   } flash_state_e;

   // Palette storage, one register per entry so it clears on reset.
   logic [RGB_W-1:0] pal_q [BANKS][ENTRIES];

   // Request capture rank and stage-1 rank.  The extra capture rank lets a
   // palette write committed one edge after the request still be seen by the
   // stage-2 read, while a write on the output edge itself is not.
   logic              req_valid_q;
   logic [IDX_W-1:0]  req_idx_q;
   logic [BSEL_W-1:0] req_bank_q;
   logic              s1_valid_q;
   logic [IDX_W-1:0]  s1_idx_q;
   logic [BSEL_W-1:0] s1_bank_q;

   // Stage-2 output registers.
   logic              out_valid_q,  out_valid_d;
   logic              out_opaque_q, out_opaque_d;
   logic [RGB_W-1:0]  out_rgb_q,    out_rgb_d;

   // Flash FSM: the state mirrors whether the down-counter is non-zero.
   flash_state_e      state_q, state_d;
   logic [7:0]        cnt_q,   cnt_d;

   // Palette write port; one entry per cycle, writes ignored in reset.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int b = 0; b < BANKS; b++) begin
            for (int e = 0; e < ENTRIES; e++) begin
               pal_q[b][e] <= '0;
            end
         end
      end else if (wr_en) begin
         pal_q[wr_bank][wr_idx] <= wr_data;
      end
   end

   // Request capture and stage-1 registers; reset drops in-flight pixels.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         req_valid_q <= 1'b0;
         req_idx_q   <= '0;
         req_bank_q  <= '0;
         s1_valid_q  <= 1'b0;
         s1_idx_q    <= '0;
         s1_bank_q   <= '0;
      end else begin
         req_valid_q <= in_valid;
         req_idx_q   <= in_index;
         req_bank_q  <= bank_sel;
         s1_valid_q  <= req_valid_q;
         s1_idx_q    <= req_idx_q;
         s1_bank_q   <= req_bank_q;
      end
   end

   // Stage-2 lookup: transparent index forces black/clear, odd flash count whitens.
   always_comb begin
      out_valid_d  = s1_valid_q;
      out_opaque_d = 1'b0;
      out_rgb_d    = '0;
      if (s1_valid_q && (s1_idx_q != TRANSP_V)) begin
         out_opaque_d = 1'b1;
         if ((state_q == ST_FLASH) && cnt_q[0]) begin
            out_rgb_d = '1;
         end else begin
            out_rgb_d = pal_q[s1_bank_q][s1_idx_q];
         end
      end
   end

   // Stage-2 output register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         out_valid_q  <= 1'b0;
         out_opaque_q <= 1'b0;
         out_rgb_q    <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_opaque_q <= out_opaque_d;
         out_rgb_q    <= out_rgb_d;
      end
   end

   // Flash next-state: a start pulse always reloads (and beats a same-cycle
   // tick); ticks only count down while flashing.
   always_comb begin
      cnt_d = cnt_q;
      if (flash_start) begin
         cnt_d = FLASH_LOAD;
      end else if (frame_tick && (state_q == ST_FLASH)) begin
         cnt_d = cnt_q - 8'd1;
      end
      state_d = (cnt_d != 8'd0) ? ST_FLASH : ST_IDLE;
   end

   // Flash state and counter registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_opaque   = out_opaque_q;
   assign red          = out_rgb_q[3*CH_W-1:2*CH_W];
   assign green        = out_rgb_q[2*CH_W-1:CH_W];
   assign blue         = out_rgb_q[CH_W-1:0];
   assign flash_active = (state_q == ST_FLASH);

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed bench for sprite_palette_bank with a request scoreboard.
module tb_sprite_palette_bank;

   localparam int IDX_W  = 4;
   localparam int BANKS  = 4;
   localparam int CH_W   = 4;
   localparam int TRANSP = 15;
   localparam int FF     = 8;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b1;
   logic        in_valid = 1'b0;
   logic [3:0]  in_index = '0;
   logic [1:0]  bank_sel = '0;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_bank = '0;
   logic [3:0]  wr_idx = '0;
   logic [11:0] wr_data = '0;
   logic        frame_tick = 1'b0;
   logic        flash_start = 1'b0;
   logic        out_valid, out_opaque, flash_active;
   logic [3:0]  red, green, blue;

   always #5 Clk = ~Clk;

   sprite_palette_bank #(
      .IDX_W(IDX_W), .BANKS(BANKS), .CH_W(CH_W),
      .TRANSP_IDX(TRANSP), .FLASH_FRAMES(FF)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .in_valid(in_valid), .in_index(in_index), .bank_sel(bank_sel),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx), .wr_data(wr_data),
      .frame_tick(frame_tick), .flash_start(flash_start),
      .out_valid(out_valid), .out_opaque(out_opaque),
      .red(red), .green(green), .blue(blue),
      .flash_active(flash_active)
   );

   typedef struct {
      bit v;
      int idx;
      int bank;
   } req_t;

   req_t        sb[$];
   logic [11:0] pal [4][16];
   int          cnt = 0;
   int          errors = 0;
   int          checks = 0;

   // Reference result for a request, given palette/flash state before its output edge.
   function automatic logic [13:0] expect_out(input req_t r);
      if (!r.v) return 14'h0;
      if (r.idx == TRANSP) return {2'b10, 12'h000};
      if ((cnt % 2) == 1) return {2'b11, 12'hFFF};
      return {2'b11, pal[r.bank][r.idx]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      in_valid = 0; in_index = 0; bank_sel = 0;
      wr_en = 0; wr_bank = 0; wr_idx = 0; wr_data = 0;
      frame_tick = 0; flash_start = 0;
   endtask

   task automatic prefill();
      req_t e;
      e.v = 0; e.idx = 0; e.bank = 0;
      sb.delete();
      sb.push_back(e);
      sb.push_back(e);
   endtask

   // One clock: push this edge's request, score the one from two edges ago,
   // then fold this edge's writes and flash events into the model.
   task automatic cyc(input string tag);
      req_t r, cur;
      logic [13:0] exp;
      @(posedge Clk);
      #1;
      r.v = in_valid; r.idx = int'(in_index); r.bank = int'(bank_sel);
      sb.push_back(r);
      if (sb.size() > 2) begin
         cur = sb.pop_front();
         exp = expect_out(cur);
         check(tag, {18'h0, out_valid, out_opaque, red, green, blue}, {18'h0, exp});
         if (cur.v)
            $display("txn %s bank=%0d idx=%0d valid=%b opaque=%b rgb=%h%h%h",
                     tag, cur.bank, cur.idx, out_valid, out_opaque, red, green, blue);
      end
      if (wr_en) pal[wr_bank][wr_idx] = wr_data;
      if (flash_start) cnt = FF;
      else if (frame_tick && cnt > 0) cnt--;
      check({tag, "/flash_active"}, {31'h0, flash_active}, {31'h0, (cnt != 0)});
      clear_inputs();
   endtask

   // Asynchronous reset pulse with writes and flash_start held during it.
   task automatic do_reset();
      #2;
      Reset_n = 0;
      #1;
      check("rst_outputs", {18'h0, out_valid, out_opaque, red, green, blue}, 32'h0);
      check("rst_flash_active", {31'h0, flash_active}, 32'h0);
      wr_en = 1; wr_bank = 1; wr_idx = 3; wr_data = 12'hFFF;
      flash_start = 1; in_valid = 1; in_index = 3; bank_sel = 1;
      repeat (2) @(posedge Clk);
      #1;
      check("rst_hold", {18'h0, out_valid, out_opaque, red, green, blue, flash_active}, 32'h0);
      clear_inputs();
      for (int b = 0; b < 4; b++)
         for (int e = 0; e < 16; e++)
            pal[b][e] = 12'h000;
      cnt = 0;
      prefill();
      @(negedge Clk);
      Reset_n = 1;
   endtask

   initial begin
      for (int b = 0; b < 4; b++)
         for (int e = 0; e < 16; e++)
            pal[b][e] = 12'h000;
      @(posedge Clk);
      #1;
      do_reset();
      cyc("post_reset");
      cyc("post_reset");

      // Basic lookup in bank 1, same index in bank 0 reads cleared entry.
      wr_en = 1; wr_bank = 1; wr_idx = 3; wr_data = 12'hD84; cyc("wr_d84");
      in_valid = 1; in_index = 3; bank_sel = 1; cyc("rd_b1_i3");
      in_valid = 1; in_index = 3; bank_sel = 0; cyc("rd_b0_i3");
      cyc("drain"); cyc("drain");

      // Transparent index hides whatever is stored.
      wr_en = 1; wr_bank = 2; wr_idx = 15; wr_data = 12'hF0F; cyc("wr_f0f");
      in_valid = 1; in_index = 15; bank_sel = 2; cyc("rd_transp");
      cyc("drain"); cyc("drain");

      // Fill banks 0/1 and stream idx 1..14 on alternating banks.
      for (int b = 0; b < 2; b++)
         for (int i = 1; i < 15; i++) begin
            wr_en = 1; wr_bank = 2'(b); wr_idx = 4'(i);
            wr_data = 12'(i * 37 + b * 91 + 5);
            cyc("fill");
         end
      for (int i = 1; i < 15; i++) begin
         in_valid = 1; in_index = 4'(i); bank_sel = 2'(i % 2); cyc("b2b");
      end
      cyc("drain"); cyc("drain");

      // Write at N+1 is visible to request at N; write at N+2 is not.
      wr_en = 1; wr_bank = 0; wr_idx = 5; wr_data = 12'h111; cyc("wr_111");
      in_valid = 1; in_index = 5; bank_sel = 0; cyc("coll_req1");
      wr_en = 1; wr_bank = 0; wr_idx = 5; wr_data = 12'h321; cyc("coll_wr_n1");
      cyc("coll_out1");
      in_valid = 1; in_index = 5; bank_sel = 0; cyc("coll_req2");
      cyc("coll_gap");
      wr_en = 1; wr_bank = 0; wr_idx = 5; wr_data = 12'h777; cyc("coll_wr_n2");
      cyc("drain"); cyc("drain");

      // Hit flash with retrigger, simultaneous start+tick, and idle ticks.
      wr_en = 1; wr_bank = 3; wr_idx = 2; wr_data = 12'h5A3; cyc("wr_5a3");
      flash_start = 1; in_valid = 1; in_index = 2; bank_sel = 3; cyc("flash_start");
      for (int k = 0; k < 5; k++) begin
         frame_tick = 1; in_valid = 1; in_index = 2; bank_sel = 3; cyc("flash_tick");
      end
      flash_start = 1; in_valid = 1; in_index = 2; bank_sel = 3; cyc("flash_retrig");
      flash_start = 1; frame_tick = 1; in_valid = 1; in_index = 2; bank_sel = 3; cyc("flash_start_tick");
      for (int k = 0; k < 8; k++) begin
         frame_tick = 1; in_valid = 1; in_index = (k == 2) ? 4'd15 : 4'd2; bank_sel = 3;
         cyc("flash_run");
      end
      for (int k = 0; k < 2; k++) begin
         frame_tick = 1; in_valid = 1; in_index = 2; bank_sel = 3; cyc("idle_tick");
      end
      cyc("drain"); cyc("drain");

      // Reset in the middle of a stream and a flash.
      flash_start = 1; in_valid = 1; in_index = 2; bank_sel = 3; cyc("pre_rst");
      in_valid = 1; in_index = 3; bank_sel = 1; cyc("pre_rst");
      in_valid = 1; in_index = 4; bank_sel = 0; cyc("pre_rst");
      do_reset();
      cyc("post_rst_idle");
      in_valid = 1; in_index = 1; bank_sel = 0; cyc("post_rst_first");
      cyc("post_rst_gap");
      cyc("post_rst_out");

      // Every entry reads back cleared after reset.
      for (int b = 0; b < 4; b++)
         for (int i = 0; i < 16; i++) begin
            in_valid = 1; in_index = 4'(i); bank_sel = 2'(b); cyc("cleared");
         end
      cyc("drain"); cyc("drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
